// File: rtl/lcd_arbiter.sv
// Two-port arbiter in front of an LCD byte driver: round-robin grant, owner lock
// across a multi-byte transaction, done/lock timeouts reported through err.
module lcd_arbiter #(
  parameter int DONE_TIMEOUT = 250000,
  parameter int LOCK_TIMEOUT = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       p0_req_i,
  input  logic [7:0] p0_data_i,
  input  logic       p0_rs_i,
  input  logic       p0_last_i,
  input  logic       p1_req_i,
  input  logic [7:0] p1_data_i,
  input  logic       p1_rs_i,
  input  logic       p1_last_i,
  output logic       p0_ack_o,
  output logic       p1_ack_o,
  output logic [7:0] drv_data_o,
  output logic       drv_rs_o,
  output logic       drv_start_o,
  input  logic       drv_done_i,
  output logic       busy_o,
  output logic       owner_o,
  output logic       err_o,
  output logic       err_lock_o,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int DW = $clog2(DONE_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [DW-1:0] DONE_LIM = DW'(DONE_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LIM = LW'(LOCK_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [7:0]    drv_data_q, drv_data_d;
  logic          drv_rs_q, drv_rs_d;
  logic          drv_start_q, drv_start_d;
  logic [1:0]    ack_q, ack_d;
  logic          err_q, err_d;
  logic          err_lock_q, err_lock_d;
  logic          last_q, last_d;
  logic          rr_last_q, rr_last_d;
  logic [DW-1:0] done_cnt_q, done_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;

  logic [1:0] req_m;
  logic       owner_req;
  logic       issue;
  logic       gnt;

  always_comb begin
    // A done timeout returns to IDLE while the ack is still up; mask that
    // requester for this cycle so its stale req is not re-granted.
    req_m       = {p1_req_i & ~ack_q[1], p0_req_i & ~ack_q[0]};
    owner_req   = owner_q ? p1_req_i : p0_req_i;
    issue       = 1'b0;
    gnt         = owner_q;
    state_d     = state_q;
    owner_d     = owner_q;
    drv_data_d  = drv_data_q;
    drv_rs_d    = drv_rs_q;
    drv_start_d = 1'b0;
    ack_d       = 2'b00;
    err_d       = 1'b0;
    err_lock_d  = 1'b0;
    last_d      = last_q;
    rr_last_d   = rr_last_q;
    done_cnt_d  = done_cnt_q;
    lock_cnt_d  = lock_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (|req_m) begin
          issue = 1'b1;
          gnt   = (&req_m) ? ~rr_last_q : req_m[1];
        end
      end
      S_WAIT: begin
        if (drv_done_i) begin
          ack_d[owner_q] = 1'b1;
          state_d        = S_ACK;
        end else if (done_cnt_q >= DONE_LIM) begin
          err_d          = 1'b1;
          ack_d[owner_q] = 1'b1;
          rr_last_d      = owner_q;
          state_d        = S_IDLE;
        end else begin
          done_cnt_d = done_cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        if (last_q) begin
          rr_last_d = owner_q;
          state_d   = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (owner_req) begin
          issue = 1'b1;
          gnt   = owner_q;
        end else if (lock_cnt_q >= LOCK_LIM) begin
          err_d      = 1'b1;
          err_lock_d = 1'b1;
          rr_last_d  = owner_q;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      owner_d     = gnt;
      drv_data_d  = gnt ? p1_data_i : p0_data_i;
      drv_rs_d    = gnt ? p1_rs_i : p0_rs_i;
      last_d      = gnt ? p1_last_i : p0_last_i;
      drv_start_d = 1'b1;
      state_d     = S_WAIT;
    end

    // Counters stop at their limit because the state leaves there, so they never wrap.
    if (issue || (state_d != state_q)) begin
      done_cnt_d = '0;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      drv_data_q  <= 8'h00;
      drv_rs_q    <= 1'b0;
      drv_start_q <= 1'b0;
      ack_q       <= 2'b00;
      err_q       <= 1'b0;
      err_lock_q  <= 1'b0;
      last_q      <= 1'b0;
      rr_last_q   <= 1'b1;
      done_cnt_q  <= '0;
      lock_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drv_data_q  <= drv_data_d;
      drv_rs_q    <= drv_rs_d;
      drv_start_q <= drv_start_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      err_lock_q  <= err_lock_d;
      last_q      <= last_d;
      rr_last_q   <= rr_last_d;
      done_cnt_q  <= done_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  assign p0_ack_o    = ack_q[0];
  assign p1_ack_o    = ack_q[1];
  assign drv_data_o  = drv_data_q;
  assign drv_rs_o    = drv_rs_q;
  assign drv_start_o = drv_start_q;
  assign busy_o      = (state_q != S_IDLE);
  assign owner_o     = owner_q;
  assign err_o       = err_q;
  assign err_lock_o  = err_lock_q;
  assign state_o     = state_q;
endmodule
